// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction fetch and load/store,
// sequencing each access through IDLE/ACCESS/DONE and tolerating a fixed memory read latency.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("unified_mem_arbiter: MEM_LAT must be in 1..4");
    end

    state_t            state_q;
    logic              owner_q;
    logic [1:0]        cnt_q;
    logic [1:0]        streak_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              pick_if;

    // Data normally wins; fetch gets through after two data grants made while it waited.
    assign pick_if = if_req && (!d_req || streak_q == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            streak_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state_q)
                IDLE: if (if_req || d_req) begin
                    state_q     <= ACCESS;
                    owner_q     <= !pick_if;
                    cnt_q       <= '0;
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= !pick_if && d_we;
                    mem_addr_q  <= pick_if ? if_addr : d_addr;
                    mem_wdata_q <= pick_if ? mem_wdata_q : d_wdata;
                    streak_q    <= (pick_if || !if_req) ? 2'd0 : streak_q + 2'd1;
                end
                // The mem_en cycle itself is not counted; the counter tracks cycles after it.
                ACCESS: if (mem_en_q && mem_we_q) begin
                    state_q   <= DONE;
                    d_valid_q <= 1'b1;
                end else if (!mem_en_q) begin
                    if (cnt_q == LAST) begin
                        state_q    <= DONE;
                        if_valid_q <= !owner_q;
                        d_valid_q  <= owner_q;
                        if_rdata_q <= owner_q ? if_rdata_q : mem_rdata;
                        d_rdata_q  <= owner_q ? mem_rdata : d_rdata_q;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = state_q != IDLE;
endmodule
